// File: rtl/regfile_arb_pkg.sv
// ============================================================================
// Module   : regfile_arb_pkg
// Brief    : Shared types and constants for the register-file port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_arb_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    localparam logic [REG_AW_DEF-1:0] X0_ADDR = 5'd0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        RESP   = 2'd2,
        LOCKED = 2'd3
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/regfile_arb_wait_cnt.sv
// ============================================================================
// Module   : regfile_arb_wait_cnt
// Brief    : Saturating starvation counter; clear has priority over increment.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_arb_wait_cnt #(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign sat_o = (cnt_q == CW'(MAX_WAIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_port_arbiter.sv
// ============================================================================
// Module   : regfile_port_arbiter
// Brief    : Shares the register-file write port and read port 2 between core
//            writeback and the debug bridge. Option: REGFILE_ARB_BURST_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_port_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int REG_AW   = REG_AW_DEF,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_we,
    input  logic [REG_AW-1:0] core_waddr,
    input  logic [XLEN-1:0]   core_wdata,
    input  logic [REG_AW-1:0] core_raddr2,
    output logic [XLEN-1:0]   core_rdata2,
    output logic              core_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [REG_AW-1:0] dbg_addr,
    input  logic [XLEN-1:0]   dbg_wdata,
`ifdef REGFILE_ARB_BURST_EN
    input  logic              dbg_lock,
`endif
    output logic              dbg_ack,
    output logic              dbg_rvalid,
    output logic [XLEN-1:0]   dbg_rdata,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic [REG_AW-1:0] rf_raddr2,
    input  logic [XLEN-1:0]   rf_rdata2
);

    arb_state_e      state_q;
    arb_state_e      state_d;
    logic [XLEN-1:0] dbg_rdata_q;
    logic [XLEN-1:0] dbg_rdata_d;

    logic w_sat;
    logic w_go;
    logic w_inc;
    logic w_clr;
    logic w_lock;
    logic w_dbg_own;

`ifdef REGFILE_ARB_BURST_EN
    assign w_lock = dbg_lock;
`else
    assign w_lock = 1'b0;
`endif

    // Debug wins on an idle write port, or once it has been starved long enough.
    assign w_go  = dbg_req && (!core_we || w_sat);
    assign w_inc = (state_q == IDLE) && dbg_req && core_we;
    assign w_clr = (state_q == IDLE) && (!dbg_req || w_go);

    regfile_arb_wait_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (w_inc),
        .clr_i (w_clr),
        .sat_o (w_sat)
    );

    always_comb begin
        state_d     = state_q;
        dbg_rdata_d = dbg_rdata_q;
        core_stall  = 1'b0;
        dbg_ack     = 1'b0;
        dbg_rvalid  = 1'b0;
        w_dbg_own   = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_go) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                core_stall = 1'b1;
                dbg_ack    = 1'b1;
                w_dbg_own  = 1'b1;
                if (!dbg_we) begin
                    dbg_rdata_d = rf_rdata2;
                    state_d     = RESP;
                end else if (w_lock) begin
                    state_d = dbg_req ? GRANT : LOCKED;
                end else begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                dbg_rvalid = 1'b1;
                core_stall = w_lock;
                if (w_lock) begin
                    state_d = dbg_req ? GRANT : LOCKED;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                core_stall = 1'b1;
                if (!w_lock) begin
                    state_d = IDLE;
                end else if (dbg_req) begin
                    state_d = GRANT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A debug write to x0 is acknowledged but never reaches the register file.
    assign rf_we       = w_dbg_own ? (dbg_we && (dbg_addr != REG_AW'(X0_ADDR)))
                                   : (core_we && !core_stall);
    assign rf_waddr    = w_dbg_own ? dbg_addr  : core_waddr;
    assign rf_wdata    = w_dbg_own ? dbg_wdata : core_wdata;
    assign rf_raddr2   = core_stall ? dbg_addr : core_raddr2;
    assign core_rdata2 = rf_rdata2;
    assign dbg_rdata   = dbg_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_port_arbiter.sv
// ============================================================================
// Module   : tb_regfile_port_arbiter
// Brief    : Self-checking bench for regfile_port_arbiter with a cycle-stamped
//            reference model and directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_regfile_port_arbiter;

    localparam int MAX_WAIT = 8;
    localparam int INF      = 32'h7fff_ffff;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_we = 1'b0;
    logic [4:0]  core_waddr = '0;
    logic [31:0] core_wdata = '0;
    logic [4:0]  core_raddr2 = '0;
    logic        dbg_req = 1'b0;
    logic        dbg_we = 1'b0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_wdata = '0;
    logic        dbg_lock = 1'b0;

    logic [31:0] core_rdata2;
    logic        core_stall;
    logic        dbg_ack;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  rf_raddr2;
    logic [31:0] rf_rdata2;

    logic [31:0] rf_mem  [32] = '{default: '0};
    logic [31:0] ref_mem [32] = '{default: '0};

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    regfile_port_arbiter #(
        .XLEN     (32),
        .REG_AW   (5),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .core_we     (core_we),
        .core_waddr  (core_waddr),
        .core_wdata  (core_wdata),
        .core_raddr2 (core_raddr2),
        .core_rdata2 (core_rdata2),
        .core_stall  (core_stall),
        .dbg_req     (dbg_req),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
`ifdef REGFILE_ARB_BURST_EN
        .dbg_lock    (dbg_lock),
`endif
        .dbg_ack     (dbg_ack),
        .dbg_rvalid  (dbg_rvalid),
        .dbg_rdata   (dbg_rdata),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .rf_raddr2   (rf_raddr2),
        .rf_rdata2   (rf_rdata2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file seen by the arbiter: x0 reads as zero.
    assign rf_rdata2 = (rf_raddr2 == 5'd0) ? 32'd0 : rf_mem[rf_raddr2];
    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rd(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : ref_mem[a];
    endfunction

    // Reference model: schedules grant / response cycles as timestamps.
    int          m_grant  = -1;
    int          m_rv     = -1;
    int          m_end    = -1;
    int          m_free   = 0;
    int          m_block  = 0;
    bit          m_hold   = 1'b0;
    logic [31:0] m_rdata  = '0;
    bit          seen_rst = 1'b0;
    int          n_stall  = 0;
    int          ack_cyc  = 0;
    logic        ack_rf_we = 1'b0;

    always @(negedge clk) begin
        bit g, r, e_stall, e_we;
        g       = (cyc == m_grant);
        r       = (cyc == m_rv);
        e_stall = g || m_hold || (r && dbg_lock);
        e_we    = g ? (dbg_we && dbg_addr != 5'd0) : (!e_stall && core_we);
        if (core_stall) n_stall++;
        if (dbg_ack) begin
            ack_cyc   = cyc;
            ack_rf_we = rf_we;
        end
        if (seen_rst) begin
            chk("ack", {31'd0, dbg_ack}, {31'd0, g});
            chk("rvalid", {31'd0, dbg_rvalid}, {31'd0, r});
            chk("stall", {31'd0, core_stall}, {31'd0, e_stall});
            chk("rdata", dbg_rdata, m_rdata);
            chk("rf_we", {31'd0, rf_we}, {31'd0, e_we});
            if (e_we) begin
                chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, g ? dbg_addr : core_waddr});
                chk("rf_wdata", rf_wdata, g ? dbg_wdata : core_wdata);
            end
            if (g) chk("rf_raddr2_dbg", {27'd0, rf_raddr2}, {27'd0, dbg_addr});
            if (!e_stall) begin
                chk("rf_raddr2_core", {27'd0, rf_raddr2}, {27'd0, core_raddr2});
                chk("core_rdata2", core_rdata2, rd(core_raddr2));
            end
        end
        if (e_we) ref_mem[g ? dbg_addr : core_waddr] = g ? dbg_wdata : core_wdata;
        if (rst) begin
            seen_rst = 1'b1;
            m_grant  = -1;
            m_rv     = -1;
            m_end    = -1;
            m_free   = cyc + 1;
            m_block  = 0;
            m_hold   = 1'b0;
            m_rdata  = '0;
        end else begin
            if (g && !dbg_we) begin
                m_rdata = rd(dbg_addr);
                m_rv    = cyc + 1;
                m_end   = cyc + 1;
            end else if (g) begin
                m_end = cyc;
            end
            if (cyc == m_end) begin
                if (dbg_lock) begin
                    if (dbg_req) m_grant = cyc + 1;
                    else m_hold = 1'b1;
                end else begin
                    m_free = cyc + 1;
                end
            end else if (m_hold) begin
                if (!dbg_lock) begin
                    m_hold = 1'b0;
                    m_free = cyc + 1;
                end else if (dbg_req) begin
                    m_hold  = 1'b0;
                    m_grant = cyc + 1;
                end
            end else if (cyc >= m_free) begin
                if (dbg_req && (!core_we || m_block == MAX_WAIT)) begin
                    m_grant = cyc + 1;
                    m_block = 0;
                    m_free  = INF;
                end else if (dbg_req && core_we) begin
                    if (m_block < MAX_WAIT) m_block++;
                end else begin
                    m_block = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one debug access; core_we is held for 'busy' cycles (-1: until ack).
    // Returns in the cycle after the ack; 'delta' is ack cycle minus request cycle.
    task automatic dbg_access(input bit we, input logic [4:0] a, input logic [31:0] d,
                              input int busy, output int delta);
        int  n;
        int  t0;
        bit  got;
        dbg_we    = we;
        dbg_addr  = a;
        dbg_wdata = d;
        dbg_req   = 1'b1;
        t0        = cyc;
        n         = 0;
        got       = 1'b0;
        delta     = -1;
        core_waddr = 5'd9;
        core_we    = (busy != 0);
        core_wdata = 32'hC000_0000 | 32'(cyc);
        while (!got && n < 40) begin
            @(negedge clk);
            if (dbg_ack) begin
                got   = 1'b1;
                delta = cyc - t0;
            end
            tick();
            n++;
            core_we    = !got && (busy < 0 || n < busy);
            core_wdata = 32'hC000_0000 | 32'(cyc);
        end
        dbg_req = 1'b0;
        core_we = 1'b0;
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout: got no ack expected ack within 40 cycles");
        end
    endtask

    initial begin
        int d;
        int s0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ack", {31'd0, dbg_ack}, 32'd0);
        chk("rst_rvalid", {31'd0, dbg_rvalid}, 32'd0);
        chk("rst_rdata", dbg_rdata, 32'd0);
        chk("rst_stall", {31'd0, core_stall}, 32'd0);
        tick();

        core_we = 1'b1; core_waddr = 5'd5; core_wdata = 32'hDEADBEEF;
        tick();
        core_we = 1'b0; core_raddr2 = 5'd5;
        tick();

        // Debug read with idle core
        s0 = n_stall;
        dbg_access(1'b0, 5'd5, 32'd0, 0, d);
        chk("read_ack_lat", 32'(d), 32'd1);
        @(negedge clk);
        chk("read_rvalid", {31'd0, dbg_rvalid}, 32'd1);
        chk("read_rdata", dbg_rdata, 32'hDEADBEEF);
        tick();
        chk("read_stall_cycles", 32'(n_stall - s0), 32'd1);

        // Debug write to x0 is dropped
        dbg_access(1'b1, 5'd0, 32'h1234, 0, d);
        chk("x0_ack_lat", 32'(d), 32'd1);
        chk("x0_rf_we", {31'd0, ack_rf_we}, 32'd0);
        tick();
        dbg_access(1'b0, 5'd0, 32'd0, 0, d);
        @(negedge clk);
        chk("x0_read", dbg_rdata, 32'd0);
        tick();

        // Core priority: busy 3 cycles, grant decided on the first free cycle
        dbg_access(1'b0, 5'd5, 32'd0, 3, d);
        chk("prio_ack_lat", 32'(d), 32'd4);
        tick();

        // Starvation: core writes every cycle
        s0 = n_stall;
        dbg_access(1'b1, 5'd3, 32'h33, -1, d);
        chk("starve_ack_lat", 32'(d), 32'd9);
        chk("starve_rf_we", {31'd0, ack_rf_we}, 32'd1);
        chk("starve_stall_cycles", 32'(n_stall - s0), 32'd1);
        tick();
        dbg_access(1'b0, 5'd3, 32'd0, 0, d);
        @(negedge clk);
        chk("starve_readback", dbg_rdata, 32'h33);
        tick();

        // Reset during RESP
        dbg_access(1'b0, 5'd5, 32'd0, 0, d);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rstresp_rvalid", {31'd0, dbg_rvalid}, 32'd0);
        chk("rstresp_rdata", dbg_rdata, 32'd0);
        chk("rstresp_ack", {31'd0, dbg_ack}, 32'd0);
        chk("rstresp_stall", {31'd0, core_stall}, 32'd0);
        tick();

`ifdef REGFILE_ARB_BURST_EN
        begin
            int acks;
            int rvs;
            bit stall_ok;
            acks = 0; rvs = 0; stall_ok = 1'b1;
            dbg_lock = 1'b1; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
            for (int n = 0; n < 40 && acks < 4; n++) begin
                @(negedge clk);
                if (dbg_ack) acks++;
                if (dbg_rvalid) rvs++;
                if (acks > 0 && !core_stall) stall_ok = 1'b0;
                tick();
            end
            dbg_lock = 1'b0; dbg_req = 1'b0;
            @(negedge clk);
            if (dbg_rvalid) rvs++;
            tick();
            @(negedge clk);
            chk("burst_rvalids", 32'(rvs), 32'd4);
            chk("burst_stall_held", {31'd0, stall_ok}, 32'd1);
            chk("burst_idle_stall", {31'd0, core_stall}, 32'd0);
            tick();
        end
`endif

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
